// File: rtl/boton_pkg.sv
// Shared types for the button press arbiter.
// BOTON_LONG_PRESS_EN enables long-press detection.
package boton_pkg;

    localparam int N_BOT_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG
    } bot_state_t;

    typedef struct packed {
        logic valid;
        logic is_long;
    } evt_t;

endpackage

// File: rtl/boton_if.sv
// Button levels in, press events out with valid/ready handshake.
// Shared by the arbiter (master) and its consumer (slave).
interface boton_if #(
    parameter int N_BOT = 4
) ();

    localparam int IDW = $clog2(N_BOT);

    logic [N_BOT-1:0] boton_db;
    logic             evt_valid;
    logic [IDW-1:0]   evt_id;
    logic             evt_long;
    logic             evt_ready;
    logic [N_BOT-1:0] ovf;

    modport master (
        input  boton_db,
        input  evt_ready,
        output evt_valid,
        output evt_id,
        output evt_long,
        output ovf
    );

    modport slave (
        output boton_db,
        output evt_ready,
        input  evt_valid,
        input  evt_id,
        input  evt_long,
        input  ovf
    );

endinterface

// File: rtl/boton_press_fsm.sv
// One button: press FSM, hold counter, one-deep pending event.
// Counter and LONG state exist only with BOTON_LONG_PRESS_EN.
module boton_press_fsm
    import boton_pkg::*;
#(
    parameter int LONG_COUNT = 150000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic take,
    output evt_t pend,
    output logic ovf
);

    bot_state_t state;
    logic       cnt_hit;
    logic       raise;
    logic       raise_long;

`ifdef BOTON_LONG_PRESS_EN
    localparam int CW = $clog2(LONG_COUNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LONG_COUNT - 1);

    logic [CW-1:0] cnt;

    assign cnt_hit = (cnt + CW'(1)) == CNT_LAST;
`else
    assign cnt_hit = 1'b0;
`endif

    always_comb begin
        raise      = 1'b0;
        raise_long = 1'b0;
        if (state == HELD) begin
            if (!btn) begin
                raise = 1'b1;
            end else if (cnt_hit) begin
                raise      = 1'b1;
                raise_long = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pend  <= '0;
            ovf   <= 1'b0;
`ifdef BOTON_LONG_PRESS_EN
            cnt   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (btn) begin
                        state <= HELD;
`ifdef BOTON_LONG_PRESS_EN
                        cnt   <= '0;
`endif
                    end
                end
                HELD: begin
                    if (!btn) begin
                        state <= IDLE;
                    end else if (cnt_hit) begin
                        state <= LONG;
                    end
`ifdef BOTON_LONG_PRESS_EN
                    if (btn) begin
                        cnt <= cnt + CW'(1);
                    end
`endif
                end
                LONG: begin
                    if (!btn) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A slot being drained this edge may take the new event.
            if (raise) begin
                if (pend.valid && !take) begin
                    ovf <= 1'b1;
                end else begin
                    pend <= '{valid: 1'b1, is_long: raise_long};
                end
            end else if (take) begin
                pend.valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/boton_arbiter.sv
// Per-button press FSMs merged into one event stream, round-robin.
// BOTON_LONG_PRESS_EN enables long-press events.
module boton_arbiter
    import boton_pkg::*;
#(
    parameter int N_BOT      = 4,
    parameter int LONG_COUNT = 150000000
) (
    input logic    clk,
    input logic    reset,
    boton_if.master bus
);

    localparam int IDW = $clog2(N_BOT);

    evt_t             pend [N_BOT];
    logic [N_BOT-1:0] pvalid;
    logic [N_BOT-1:0] take;
    logic [N_BOT-1:0] ovf;

    logic [IDW-1:0]   prio;
    logic [IDW-1:0]   sel;
    logic [IDW-1:0]   idx;
    logic [IDW:0]     tmp;
    logic             found;
    logic             load;

    logic             out_valid;
    logic [IDW-1:0]   out_id;
    logic             out_long;

    for (genvar i = 0; i < N_BOT; i++) begin : g_bot
        boton_press_fsm #(
            .LONG_COUNT(LONG_COUNT)
        ) u_fsm (
            .clk  (clk),
            .reset(reset),
            .btn  (bus.boton_db[i]),
            .take (take[i]),
            .pend (pend[i]),
            .ovf  (ovf[i])
        );
        assign pvalid[i] = pend[i].valid;
    end

    // prio is the index searched first; it follows the last grant.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        tmp   = '0;
        for (int k = 0; k < N_BOT; k++) begin
            tmp = {1'b0, prio} + (IDW+1)'(k);
            if (tmp >= (IDW+1)'(N_BOT)) begin
                tmp = tmp - (IDW+1)'(N_BOT);
            end
            idx = tmp[IDW-1:0];
            if (!found && pvalid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        load = found && (!out_valid || bus.evt_ready);
        take = '0;
        if (load) begin
            take[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            out_long  <= 1'b0;
            prio      <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_id    <= sel;
            out_long  <= pend[sel].is_long;
            prio      <= (sel == IDW'(N_BOT - 1)) ? '0 : sel + IDW'(1);
        end else if (bus.evt_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.evt_valid = out_valid;
    assign bus.evt_id    = out_id;
`ifdef BOTON_LONG_PRESS_EN
    assign bus.evt_long  = out_long;
`else
    assign bus.evt_long  = 1'b0;
`endif
    assign bus.ovf       = ovf;

endmodule

// File: doc/boton_arbiter.md
BOTON_ARBITER -- requirements
Module: boton_arbiter

Interface
REQ-001 Parameter N_BOT, default 4: number of debounced button inputs, legal range 2..8.
REQ-002 Parameter LONG_COUNT, default 150000000: hold time in clocks that classifies a press as long (3 s at 50 MHz); legal minimum 2.
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 boton_db  input  N_BOT  debounced button levels from the debouncer instances; 1 = pressed.
REQ-006 evt_valid  output  1  an event is presented on evt_id and evt_long.
REQ-007 evt_id  output  $clog2(N_BOT)  index of the button that generated the presented event.
REQ-008 evt_long  output  1  1 = long press, 0 = short press.
REQ-009 evt_ready  input  1  consumer accepts the event on a clock edge where evt_valid=1 and evt_ready=1.
REQ-010 ovf  output  N_BOT  sticky per-button flags: an event was dropped.

Function
REQ-011 Each button SHALL run its own FSM with states IDLE, HELD and LONG.
- IDLE->HELD when boton_db[i]=1 is sampled; the hold counter is cleared.
- HELD with boton_db[i]=1: counter increments; when it reaches LONG_COUNT-1, go to LONG and raise a long event.
- HELD with boton_db[i]=0: raise a short event and return to IDLE.
- LONG with boton_db[i]=0: return to IDLE with no event; stay in LONG while boton_db[i] is held.
REQ-012 The hold counter SHALL be $clog2(LONG_COUNT+1) bits wide and SHALL never wrap.
REQ-013 Each button SHALL own a one-deep pending register holding a valid bit and a long bit, set on the edge that raises the event.
REQ-014 An event raised while pending[i] is already valid SHALL be dropped and SHALL set ovf[i].
- Exception: if pending[i] is transferred to the output on that same edge, the new event is captured and ovf[i] is not set.
REQ-015 A round-robin arbiter SHALL load the output register whenever it is empty or being accepted this edge.
- It selects the first valid pending index after the last granted index, wrapping N_BOT-1->0; after reset, index 0 has top priority.
REQ-016 The output register SHALL keep evt_valid, evt_id and evt_long stable while evt_valid=1 and evt_ready=0.
REQ-017 Latency: if the release is sampled at edge k, pending is valid after edge k and evt_valid=1 after edge k+1, provided the output is free and button i wins arbitration.
REQ-018 Back-to-back operation: on an accept edge with another pending event, evt_valid SHALL stay 1 and the new event SHALL be presented the next cycle (no bubble).
REQ-019 Simultaneous events on several buttons in one cycle SHALL all be captured into their own pending registers.

Reset
REQ-020 On reset=0, all of the following SHALL be cleared immediately and asynchronously:
- all FSMs to IDLE and all counters to 0;
- all pending registers invalid;
- evt_valid=0, evt_id=0, evt_long=0, ovf=0;
- the round-robin pointer, so that index 0 has top priority.
REQ-021 Reset mid-press SHALL discard the press; if the button is still held when reset releases, the press SHALL be treated as a new press starting from 0.

Configuration
REQ-022 Macro BOTON_LONG_PRESS_EN compiles in the hold counters, the LONG state and long-event generation.
REQ-023 Without BOTON_LONG_PRESS_EN: no counters are built, every press emits one short event on release, evt_long is tied to 0, and LONG_COUNT is ignored.

Structure
REQ-024 Package boton_pkg SHALL hold:
- the per-button FSM state typedef (IDLE/HELD/LONG);
- the event struct {valid, long};
- constant N_BOT_MAX=8.
REQ-025 Sub-module boton_press_fsm SHALL contain one button's FSM, hold counter and pending register, and SHALL be instantiated N_BOT times.
- The arbiter and output register stay in boton_arbiter.

Verification (bench: N_BOT=4, LONG_COUNT=10, macro defined unless stated)
REQ-026 Short press: hold button 2 for 5 cycles with evt_ready=1 -> evt_id=2, evt_long=0, evt_valid high exactly 1 cycle, 2 cycles after the release edge.
REQ-027 Long press: hold button 1 for 30 cycles -> one event evt_id=1, evt_long=1 while the button is still held, and no event on release.
REQ-028 Arbitration: release buttons 0 and 3 in the same cycle with evt_ready=1 -> evt_id=0 then evt_id=3 on consecutive cycles; repeat -> 0 then 3 again (pointer at 3 wraps to 0 first).
REQ-029 Backpressure/overflow: evt_ready=0 while button 0 makes 3 short presses -> the first event is held stable and ovf[0]=1; raise evt_ready -> exactly 2 events delivered.
REQ-030 Reset: assert reset while button 2 has been held 8 cycles -> outputs are 0 at once; after reset releases, hold 3 more cycles and release -> short event for button 2.
REQ-031 Macro undefined: hold button 1 for 30 cycles -> a single short event on release and evt_long=0.
